// File: rtl/sead_fault_injector.sv
// Multi-channel fault-injection sequencer for SEAD-protected state: corrupts read-path
// words by programmable mask/mode/window and times the checker's detection latency.
module sead_fault_injector #(
  parameter int WIDTH    = 32,
  parameter int CHANNELS = 2,
  parameter int CH_W     = 1,
  parameter int CNT_W    = 16,
  parameter int TIMEOUT  = 1000
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      cfg_we,
  input  logic [CH_W-1:0]           cfg_ch,
  input  logic [1:0]                cfg_mode,
  input  logic [WIDTH-1:0]          cfg_mask,
  input  logic [CNT_W-1:0]          cfg_delay,
  input  logic [CNT_W-1:0]          cfg_dur,
  input  logic                      arm,
  input  logic [CHANNELS*WIDTH-1:0] data_in,
  output logic [CHANNELS*WIDTH-1:0] data_out,
  input  logic                      err_detect,
  output logic                      busy,
  output logic                      done,
  output logic                      detected,
  output logic                      false_alarm,
  output logic                      timed_out,
  output logic [CNT_W-1:0]          det_latency
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;
  typedef enum logic [1:0] {MODE_OFF, MODE_FLIP, MODE_SA0, MODE_SA1} mode_e;

  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

  state_e           state_q, state_d;
  mode_e            mode_q  [CHANNELS];
  logic [WIDTH-1:0] mask_q  [CHANNELS];
  logic [CNT_W-1:0] delay_q [CHANNELS];
  logic [CNT_W-1:0] dur_q   [CHANNELS];

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             first_vld_q, first_vld_d;
  logic [CNT_W-1:0] first_q, first_d;
  logic             detected_q, detected_d;
  logic             false_alarm_q, false_alarm_d;
  logic             timed_out_q, timed_out_d;
  logic [CNT_W-1:0] latency_q, latency_d;

  logic [CHANNELS-1:0] active;
  logic                any_active;
  logic                start;
  logic                cfg_wr;
  logic                det_hit;
  logic                to_hit;

  function automatic logic [WIDTH-1:0] corrupt(input mode_e m, input logic [WIDTH-1:0] d,
                                               input logic [WIDTH-1:0] mk);
    case (m)
      MODE_FLIP: return d ^ mk;
      MODE_SA0:  return d & ~mk;
      MODE_SA1:  return d | mk;
      default:   return d;
    endcase
  endfunction

  // The window end is one bit wider so delay + dur never wraps back below cnt.
  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic [CNT_W:0] win_end;
    assign win_end   = {1'b0, delay_q[c]} + {1'b0, dur_q[c]};
    assign active[c] = (state_q == S_RUN) && (mode_q[c] != MODE_OFF) &&
                       (cnt_q >= delay_q[c]) &&
                       ((dur_q[c] == '0) || ({1'b0, cnt_q} < win_end));
    assign data_out[c*WIDTH +: WIDTH] = active[c]
        ? corrupt(mode_q[c], data_in[c*WIDTH +: WIDTH], mask_q[c])
        : data_in[c*WIDTH +: WIDTH];
  end

  assign any_active = |active;
  assign start      = (state_q != S_RUN) && arm;
  assign cfg_wr     = cfg_we && (state_q != S_RUN) && (32'(cfg_ch) < CHANNELS);
  assign det_hit    = err_detect && (first_vld_q || any_active);
  assign to_hit     = (cnt_q == TO_LAST);

  // NOTE: the config words are a handful of flops, not a RAM, so they reset like any other state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int c = 0; c < CHANNELS; c++) begin
        mode_q[c]  <= MODE_OFF;
        mask_q[c]  <= '0;
        delay_q[c] <= '0;
        dur_q[c]   <= '0;
      end
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (cfg_wr && (cfg_ch == CH_W'(c))) begin
          mode_q[c]  <= mode_e'(cfg_mode);
          mask_q[c]  <= cfg_mask;
          delay_q[c] <= cfg_delay;
          dur_q[c]   <= cfg_dur;
        end
      end
    end
  end

  // NOTE: sequential blocks use <= so every flop samples pre-edge values regardless of order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: if (arm) state_d = S_RUN;
      S_RUN:          if (err_detect || to_hit) state_d = S_DONE;
      default:        state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == S_RUN);
    done = (state_q == S_DONE);
  end

  // NOTE: every _d takes its hold value first so no path through this block infers a latch.
  always_comb begin
    cnt_d         = cnt_q;
    first_vld_d   = first_vld_q;
    first_d       = first_q;
    detected_d    = detected_q;
    false_alarm_d = false_alarm_q;
    timed_out_d   = timed_out_q;
    latency_d     = latency_q;
    if (start) begin
      cnt_d         = '0;
      first_vld_d   = 1'b0;
      first_d       = '0;
      detected_d    = 1'b0;
      false_alarm_d = 1'b0;
      timed_out_d   = 1'b0;
      latency_d     = '0;
    end else if (state_q == S_RUN) begin
      if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
      if (any_active && !first_vld_q) begin
        first_vld_d = 1'b1;
        first_d     = cnt_q;
      end
      if (det_hit) begin
        detected_d = 1'b1;
        latency_d  = first_vld_q ? (cnt_q - first_q) : '0;
      end else if (err_detect) begin
        false_alarm_d = 1'b1;
      end else if (to_hit) begin
        timed_out_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q         <= '0;
      first_vld_q   <= 1'b0;
      first_q       <= '0;
      detected_q    <= 1'b0;
      false_alarm_q <= 1'b0;
      timed_out_q   <= 1'b0;
      latency_q     <= '0;
    end else begin
      cnt_q         <= cnt_d;
      first_vld_q   <= first_vld_d;
      first_q       <= first_d;
      detected_q    <= detected_d;
      false_alarm_q <= false_alarm_d;
      timed_out_q   <= timed_out_d;
      latency_q     <= latency_d;
    end
  end

  assign detected    = detected_q;
  assign false_alarm = false_alarm_q;
  assign timed_out   = timed_out_q;
  assign det_latency = latency_q;

endmodule
